// File: rtl/load_wb_sequencer.sv
// Writeback sequencer: takes one request from the main control unit, runs the load read/wait/MDR
// strobe when needed, then pulses reg_wr/done for one cycle with a registered, held wb_sel.
module load_wb_sequencer #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] wb_class,
  input  logic [2:0] funct3,
  input  logic       slt_true,
  input  logic [4:0] rd,
  output logic       mem_rd,
  output logic       mdr_load,
  output logic [3:0] wb_sel,
  output logic       reg_wr,
  output logic [4:0] wb_rd,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  localparam logic [2:0] CLS_ALU   = 3'd0;
  localparam logic [2:0] CLS_LOAD  = 3'd1;
  localparam logic [2:0] CLS_SLT   = 3'd2;
  localparam logic [2:0] CLS_LINK  = 3'd3;
  localparam logic [2:0] CLS_SHIFT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_WAIT,
    S_MDR_LOAD,
    S_WRITE,
    S_ERR
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [2:0] r_cls;
  logic [2:0] r_f3;
  logic       r_slt;
  logic [4:0] r_rd;
  logic [3:0] r_wb_sel;
  logic [3:0] w_sel_nxt;
  logic       w_req_valid;
  logic       w_accept;

  function automatic logic [3:0] sel_of(input logic [2:0] cls, input logic [2:0] f3,
                                        input logic slt);
    logic [3:0] s;
    s = 4'b0000;
    case (cls)
      CLS_ALU:   s = 4'b0000;
      CLS_LOAD: begin
        case (f3)
          3'b000:  s = 4'b0110;
          3'b001:  s = 4'b0111;
          3'b010:  s = 4'b1000;
          3'b011:  s = 4'b0101;
          3'b100:  s = 4'b1001;
          3'b101:  s = 4'b1010;
          3'b110:  s = 4'b1011;
          default: s = 4'b0000;
        endcase
      end
      CLS_SLT:   s = slt ? 4'b0010 : 4'b0011;
      CLS_LINK:  s = 4'b0100;
      CLS_SHIFT: s = 4'b1100;
      default:   s = 4'b0000;
    endcase
    return s;
  endfunction

  // Classes 5..7 and the reserved load width are rejected at acceptance time.
  always_comb begin
    w_req_valid = 1'b0;
    if (wb_class == CLS_LOAD) w_req_valid = (funct3 != 3'b111);
    else if (wb_class <= CLS_SHIFT) w_req_valid = 1'b1;
  end

  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_sel_nxt = r_wb_sel;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!w_req_valid) begin
            w_next = S_ERR;
          end else if (wb_class == CLS_LOAD) begin
            w_next    = S_MEM_WAIT;
            w_cnt_nxt = LAT_M1;
          end else begin
            w_next    = S_WRITE;
            w_sel_nxt = sel_of(wb_class, funct3, slt_true);
          end
        end
      end
      S_MEM_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next    = S_MDR_LOAD;
          w_sel_nxt = sel_of(r_cls, r_f3, r_slt);
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_MDR_LOAD: w_next = S_WRITE;
      S_WRITE:    w_next = S_IDLE;
      S_ERR:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_wb_sel <= 4'b0000;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_nxt;
      r_wb_sel <= w_sel_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cls <= 3'd0;
      r_f3  <= 3'd0;
      r_slt <= 1'b0;
      r_rd  <= 5'd0;
    end else if (w_accept) begin
      r_cls <= wb_class;
      r_f3  <= funct3;
      r_slt <= slt_true;
      r_rd  <= rd;
    end
  end

  // Moore outputs only: nothing here sees start, so reg_wr has no path from it.
  always_comb begin
    mem_rd   = 1'b0;
    mdr_load = 1'b0;
    reg_wr   = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_MEM_WAIT: mem_rd = (r_cnt == LAT_M1);
      S_MDR_LOAD: mdr_load = 1'b1;
      S_WRITE: begin
        done   = 1'b1;
        reg_wr = (r_rd != 5'd0);
      end
      S_ERR: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

  assign wb_sel = r_wb_sel;
  assign wb_rd  = r_rd;

endmodule

// File: doc/load_wb_sequencer.md
Name: load_wb_sequencer

Overview:
Multicycle sequencer for the register-file writeback path of the 64-bit RISC-V core. Accepts one writeback request from the main control unit and, for loads, issues the memory read, waits a fixed memory latency and strobes the memory-data register. It then drives the 4-bit writeback-mux select and the register-file write enable for exactly one cycle. It sits between the main control FSM and the writeback mux / register file.

Parameters:
MEM_LAT, 2, memory read latency in cycles from mem_rd to valid data (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request pulse, sampled only in IDLE
wb_class  in  3  0=ALU, 1=LOAD, 2=SLT, 3=LINK(PC), 4=SHIFT; 5..7 illegal
funct3  in  3  load width/sign field; used only when wb_class=LOAD
slt_true  in  1  comparison result; used only when wb_class=SLT
rd  in  5  destination register index
mem_rd  out  1  memory read strobe
mdr_load  out  1  memory-data-register load enable
wb_sel  out  4  writeback-mux select
reg_wr  out  1  register-file write enable
wb_rd  out  5  latched destination index
busy  out  1  request in progress
done  out  1  one-cycle completion pulse
illegal  out  1  one-cycle pulse, concurrent with done, on an invalid request

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0, all outputs 0, wb_sel=4'b0000, wb_rd=0.
- Request latching: on start in IDLE, latch wb_class, funct3, slt_true and rd. Outputs depend only on the latched copies; later input changes are ignored.
- start while busy=1 is ignored; it is not queued.

wb_sel encoding (fixed):
- ALU=0000, ld=0101, one=0010, zero=0011, PC=0100.
- lb=0110, lh=0111, lw=1000, lbu=1001, lhu=1010, lwu=1011, SHIFT=1100.
- SLT selects 0010 if slt_true, else 0011.
- Load funct3 mapping: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 illegal.

States:
- IDLE: busy=0.
  - start with a valid non-load class -> WRITE.
  - start with LOAD and funct3 != 111 -> MEM_WAIT, counter=MEM_LAT-1.
  - start with an illegal class or load funct3=111 -> ERR.
- MEM_WAIT: busy=1. mem_rd=1 only in the first MEM_WAIT cycle. Counter decrements each cycle; at 0 -> MDR_LOAD.
- MDR_LOAD: busy=1, mdr_load=1 for one cycle -> WRITE.
- WRITE: busy=1, done=1. reg_wr=1 unless the latched rd=0 (x0 writes suppressed; done still pulses) -> IDLE.
- ERR: busy=1, done=1, illegal=1, reg_wr=0, mem_rd never asserted -> IDLE.

Output rules:
- wb_sel is registered. It is updated on entry to MDR_LOAD for loads, and on entry to WRITE otherwise. It holds its value through IDLE until the next request, so the mux output stays stable.
- wb_rd is registered at start.
- Latency, with start in cycle 0:
  - Non-load: WRITE in cycle 1.
  - Load: mem_rd in cycle 1, mdr_load in cycle MEM_LAT+1, WRITE in cycle MEM_LAT+2.
- Back-to-back: start may be accepted in the first IDLE cycle after WRITE/ERR. There is no combinational path from start to reg_wr.
- Reset asserted mid-load: the operation aborts, and reg_wr, mdr_load and done never pulse for that request.
- Counter width is 4 bits; MEM_LAT=1 gives exactly one MEM_WAIT cycle.

Test Plan:
- Reset, then wb_class=0, rd=5, start in cycle 0 -> cycle 1: done=1, reg_wr=1, wb_sel=0000, wb_rd=5; cycle 2: busy=0, wb_sel still 0000.
- MEM_LAT=2, LOAD with funct3=000 (lb), rd=7 -> mem_rd in cycle 1 only; mdr_load in cycle 3 with wb_sel=0110; cycle 4: reg_wr=1, done=1. Repeat for funct3 001..110 -> wb_sel 0111, 1000, 0101, 1001, 1010, 1011.
- SLT with slt_true=1 -> wb_sel=0010; slt_true=0 -> 0011. LINK -> 0100, SHIFT -> 1100. With rd=0 -> done=1, reg_wr=0.
- LOAD with funct3=111, or wb_class=6 -> cycle 1: done=1, illegal=1, reg_wr=0; mem_rd never asserted.
- Start a load, then raise start again and change inputs in cycles 1..3 -> second request ignored; the first completes with its original rd and wb_sel; busy deasserts after cycle 4.
- Assert reset asynchronously in cycle 2 of a load -> all outputs 0 immediately, wb_sel=0000; no later reg_wr/done; a new ALU request after reset completes in 1 cycle.
